// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared constants and helpers for the parametrised serial pattern detector.
//   - SEQ_DET_DEFAULT_PATTERN : reset value of the pattern register (4'b1011)
//   - SEQ_DET_OVERLAP / SEQ_DET_NONOVERLAP : encodings of the overlap_en input
//   - seq_det_fill_w()        : width of the fill counter holding 0..PAT_W
`timescale 1ns/1ps

package seq_det_pkg;

    localparam logic [3:0] SEQ_DET_DEFAULT_PATTERN = 4'b1011;

    localparam logic SEQ_DET_OVERLAP    = 1'b1;
    localparam logic SEQ_DET_NONOVERLAP = 1'b0;

    function automatic int seq_det_fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_match_counter.sv
// seq_det_match_counter
//   Saturating up-counter for detected matches. A clear request beats a
//   concurrent increment, so the match arriving in the clear cycle is lost.
//   Ports:
//     clock, reset : rising-edge clock, asynchronous active-high reset
//     inc          : count one match this cycle
//     clear        : synchronous clear to zero
//     count        : CNT_W-bit count, sticks at all-ones
`timescale 1ns/1ps

module seq_det_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Detects a runtime-loadable PAT_W-bit pattern (MSB received first) on a
//   qualified serial stream. detector_out is a registered one-cycle pulse in
//   the cycle after the edge that accepted the final pattern bit.
//   Ports:
//     clock, reset    : rising-edge clock, asynchronous active-high reset
//     sequence_in     : serial data bit, sampled when sequence_valid = 1
//     sequence_valid  : qualifies sequence_in; gaps hold the partial match
//     overlap_en      : 1 = overlapping, 0 = restart after every match
//     pattern_load    : load pattern_in (and mask); flushes history
//     pattern_in      : new pattern, MSB first
//     count_clear     : synchronous clear of match_count (beats a match)
//     detector_out    : registered match pulse
//     match_count     : saturating match count
//   Optional build macro SEQ_DETECTOR_PARAM_MASK_EN adds pattern_mask_in and a
//   mask register; mask bits of 0 are don't-care positions.
`timescale 1ns/1ps

module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQ_DET_DEFAULT_PATTERN),
    parameter int               CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sequence_in,
    input  logic             sequence_valid,
    input  logic             overlap_en,
    input  logic             pattern_load,
    input  logic [PAT_W-1:0] pattern_in,
`ifdef SEQ_DETECTOR_PARAM_MASK_EN
    input  logic [PAT_W-1:0] pattern_mask_in,
`endif
    input  logic             count_clear,
    output logic             detector_out,
    output logic [CNT_W-1:0] match_count
);

    localparam int               FILL_W    = seq_det_fill_w(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pattern_q;
    logic [PAT_W-1:0]  hist_q;
    logic [FILL_W-1:0] fill_q;

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    logic [PAT_W-1:0]  diff;
    logic              match;

`ifdef SEQ_DETECTOR_PARAM_MASK_EN
    logic [PAT_W-1:0]  mask_q;
`endif

    always_comb begin
        hist_n = {hist_q[PAT_W-2:0], sequence_in};
        fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
`ifdef SEQ_DETECTOR_PARAM_MASK_EN
        diff   = (hist_n ^ pattern_q) & mask_q;
`else
        diff   = hist_n ^ pattern_q;
`endif
        // The fill check keeps an all-zero pattern from matching the cleared history.
        match  = sequence_valid && !pattern_load &&
                 (fill_n == FILL_FULL) && (diff == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern_q    <= PATTERN;
            hist_q       <= '0;
            fill_q       <= '0;
            detector_out <= 1'b0;
`ifdef SEQ_DETECTOR_PARAM_MASK_EN
            mask_q       <= '1;
`endif
        end else if (pattern_load) begin
            // Any bit presented alongside the load is dropped.
            pattern_q    <= pattern_in;
            hist_q       <= '0;
            fill_q       <= '0;
            detector_out <= 1'b0;
`ifdef SEQ_DETECTOR_PARAM_MASK_EN
            mask_q       <= pattern_mask_in;
`endif
        end else if (sequence_valid) begin
            hist_q       <= hist_n;
            detector_out <= match;
            if (match && (overlap_en == SEQ_DET_NONOVERLAP)) begin
                fill_q <= '0;
            end else begin
                fill_q <= fill_n;
            end
        end else begin
            detector_out <= 1'b0;
        end
    end

    seq_det_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clock (clock),
        .reset (reset),
        .inc   (match),
        .clear (count_clear),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
`timescale 1ns/1ps

module tb_seq_detector_param;

    typedef struct {
        logic       valid;
        logic       din;
        logic       ovl;
        logic       load;
        logic [3:0] pat;
        logic       clr;
        logic       exp_det;
        logic [7:0] exp_cnt;
        logic [1:0] exp_cnt2;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sequence_in = 1'b0;
    logic       sequence_valid = 1'b0;
    logic       overlap_en = 1'b1;
    logic       pattern_load = 1'b0;
    logic [3:0] pattern_in = 4'b0000;
    logic       count_clear = 1'b0;
    logic       detector_out, detector_out2;
    logic [7:0] match_count;
    logic [1:0] match_count2;

    int tests_run = 0;
    int tests_failed = 0;

    // Running expected counts, advanced as vectors are built.
    logic [7:0] cnt_m  = 8'd0;
    logic [1:0] cnt2_m = 2'd0;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clock = ~clock;

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .sequence_in    (sequence_in),
        .sequence_valid (sequence_valid),
        .overlap_en     (overlap_en),
        .pattern_load   (pattern_load),
        .pattern_in     (pattern_in),
`ifdef SEQ_DETECTOR_PARAM_MASK_EN
        .pattern_mask_in(4'hF),
`endif
        .count_clear    (count_clear),
        .detector_out   (detector_out),
        .match_count    (match_count)
    );

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_sat (
        .clock          (clock),
        .reset          (reset),
        .sequence_in    (sequence_in),
        .sequence_valid (sequence_valid),
        .overlap_en     (overlap_en),
        .pattern_load   (pattern_load),
        .pattern_in     (pattern_in),
`ifdef SEQ_DETECTOR_PARAM_MASK_EN
        .pattern_mask_in(4'hF),
`endif
        .count_clear    (count_clear),
        .detector_out   (detector_out2),
        .match_count    (match_count2)
    );

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic din, input logic ovl,
                                input logic load, input logic [3:0] pat, input logic clr,
                                input logic exp_det);
        vec_t v;
        v.valid = valid; v.din = din; v.ovl = ovl; v.load = load;
        v.pat = pat; v.clr = clr; v.exp_det = exp_det;
        if (clr) begin
            cnt_m  = 8'd0;
            cnt2_m = 2'd0;
        end else if (exp_det) begin
            if (cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
            if (cnt2_m != 2'd3) cnt2_m = cnt2_m + 2'd1;
        end
        v.exp_cnt  = cnt_m;
        v.exp_cnt2 = cnt2_m;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clock);
        sequence_valid = v.valid;
        sequence_in    = v.din;
        overlap_en     = v.ovl;
        pattern_load   = v.load;
        pattern_in     = v.pat;
        count_clear    = v.clr;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check("det",   idx, 32'(detector_out),  32'(e.exp_det));
        check("det2",  idx, 32'(detector_out2), 32'(e.exp_det));
        check("cnt",   idx, 32'(match_count),   32'(e.exp_cnt));
        check("cnt2",  idx, 32'(match_count2),  32'(e.exp_cnt2));
    endtask

    task automatic check_zero(input int idx);
        check("rst_det",  idx, 32'(detector_out),  32'd0);
        check("rst_cnt",  idx, 32'(match_count),   32'd0);
        check("rst_det2", idx, 32'(detector_out2), 32'd0);
        check("rst_cnt2", idx, 32'(match_count2),  32'd0);
        cnt_m  = 8'd0;
        cnt2_m = 2'd0;
    endtask

    task automatic add_stream(input logic [31:0] bits, input int n, input logic ovl,
                              input logic [31:0] dets);
        for (int i = 0; i < n; i++) begin
            vecs.push_back(mk(1'b1, bits[n-1-i], ovl, 1'b0, 4'b0000, 1'b0, dets[n-1-i]));
        end
    endtask

    initial begin
        logic [24:0] sat_bits;
        int k;

        repeat (2) @(negedge clock);
        check_zero(0);
        reset = 1'b0;
        @(negedge clock);
        check_zero(1);

        // Default pattern 1011, overlapping: pulses after bits 4 and 7.
        add_stream(32'b1011011, 7, 1'b1, 32'b0001001);
        // Flush, then non-overlapping: only the first match.
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0));
        add_stream(32'b1011011, 7, 1'b0, 32'b0001000);
        // Gap in the stream keeps the partial match.
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0));
        add_stream(32'b10, 2, 1'b1, 32'b00);
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0));
        add_stream(32'b11, 2, 1'b1, 32'b01);
        // All-zero pattern needs four bits; a load drops the concurrent bit.
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0));
        add_stream(32'b00000, 5, 1'b1, 32'b00011);
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0));
        add_stream(32'b0000, 4, 1'b1, 32'b0001);
        // Eight overlapping matches; 2-bit counter saturates at 3.
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0));
        sat_bits = 25'b1011011011011011011011011;
        for (int i = 0; i < 25; i++) begin
            k = i + 1;
            vecs.push_back(mk(1'b1, sat_bits[24-i], 1'b1, 1'b0, 4'b0000, 1'b0,
                              (k >= 4) && ((k - 4) % 3 == 0)));
        end
        // Clear wins over a coincident match.
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Asynchronous reset while a pulse is being presented.
        apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0), 100);
        apply(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0), 101);
        apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0), 102);
        apply(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0), 103);
        apply(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1), 104);
        #2 reset = 1'b1;
        #1 check_zero(105);
        @(negedge clock);
        reset = 1'b0;

        // Reset after 1,0,1: the trailing 1 alone must not complete a match.
        apply(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0), 106);
        apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0), 107);
        apply(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0), 108);
        #2 reset = 1'b1;
        #1 check_zero(109);
        @(negedge clock);
        reset = 1'b0;
        apply(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0), 110);
        apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0), 111);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the fixed 4-bit Moore sequence detector.
- Detects a PAT_W-bit serial pattern on a qualified 1-bit input stream. The pattern is runtime-loadable and overlap/non-overlap mode is selectable.
- Output pulse is registered (Moore timing). A saturating match counter is included.
- Sits between the serial bit source and control logic that consumes match pulses and counts.

Parameters:
- PAT_W, 4, pattern length in bits (2..32).
- PATTERN, 4'b1011 (PAT_W bits), reset value of the pattern register; MSB is the earliest bit received.
- CNT_W, 8, width of match_count.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- sequence_in  input  1  serial data bit.
- sequence_valid  input  1  sequence_in is sampled only when this is 1.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- pattern_load  input  1  load pattern_in into the pattern register.
- pattern_in  input  PAT_W  new pattern, MSB first.
- count_clear  input  1  synchronous clear of match_count.
- detector_out  output  1  registered one-cycle match pulse.
- match_count  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (async, active-high):
  - pattern_q = PATTERN; hist = 0; fill = 0.
  - detector_out = 0; match_count = 0.
- State:
  - hist: PAT_W-bit shift register, newest bit in LSB.
  - fill: counter 0..PAT_W, width $clog2(PAT_W+1); counts valid bits held.
- Accepted bit (sequence_valid=1, pattern_load=0):
  - hist_n = {hist[PAT_W-2:0], sequence_in}.
  - fill_n = min(fill+1, PAT_W).
  - match = (fill_n == PAT_W) && (hist_n == pattern_q).
  - hist <= hist_n; detector_out <= match.
  - If match and overlap_en=0: fill <= 0, so the next match needs PAT_W fresh bits. Otherwise fill <= fill_n.
- Latency: detector_out is high for exactly the one cycle following the edge that accepted the final pattern bit.
- sequence_valid=0: hist and fill hold; detector_out <= 0. Gaps in the stream do not break a partial match.
- pattern_load=1 (priority over sequence_valid):
  - pattern_q <= pattern_in; hist <= 0; fill <= 0; detector_out <= 0.
  - Any concurrent input bit is dropped.
  - match_count is unaffected.
- overlap_en: sampled at each match; changing it mid-stream takes effect at the next match.
- match_count:
  - Increments on each cycle where match=1.
  - Saturates at 2^CNT_W-1, with no wrap.
  - count_clear=1 sets it to 0. Clear wins over a simultaneous match, so that match is not counted.
- No match can fire before PAT_W valid bits have been accepted since reset, load, or the last non-overlap match. This holds even if the pattern is all zeros.

Optional Feature:
- Macro: SEQ_DETECTOR_PARAM_MASK_EN.
- Defined:
  - Adds input pattern_mask_in [PAT_W] and a mask register, reset to all-ones and loaded together with pattern_in on pattern_load.
  - Bit positions with mask=0 are don't-care: match = (fill_n == PAT_W) && (((hist_n ^ pattern_q) & mask_q) == 0).
- Not defined: no mask port or register; exact-match comparison as above.

Decomposition:
- Package seq_det_pkg:
  - Function/constant for the fill-counter width, $clog2(PAT_W+1).
  - Default pattern constant SEQ_DET_DEFAULT_PATTERN = 4'b1011.
  - Overlap-mode encoding constants: SEQ_DET_OVERLAP = 1'b1, SEQ_DET_NONOVERLAP = 1'b0.
- Sub-module seq_det_match_counter: CNT_W saturating counter with inc and clear inputs, clear priority. Hist/fill/compare logic stays in the top module.

Test Plan:
- Reset defaults, overlap_en=1, stream 1,0,1,1,0,1,1 (all valid) -> detector_out pulses after bits 4 and 7; match_count=2.
- Same stream with overlap_en=0 -> single pulse after bit 4; match_count=1.
- Stream 1,0 then sequence_valid=0 for 3 cycles, then 1,1 -> detector_out low during the gap, one pulse after the final 1.
- pattern_load with pattern_in=4'b0000 right after reset, then four valid 0s -> no pulse after bits 1-3, pulse after bit 4.
  - A load asserted mid-sequence with a valid bit present must drop that bit and restart fill.
- CNT_W=2, eight matches of 1011 in overlap mode (stream 1011011011011011011011011) -> match_count sticks at 3.
  - Then count_clear coincident with a match -> match_count=0.
- Assert reset asynchronously mid-pattern (after 1,0,1) -> detector_out and match_count drop to 0 immediately.
  - After release, the remaining bit 1 alone yields no pulse.
